pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per pipeline stage; WIDTH SHALL be an integer multiple of CHUNK, and STAGES = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: operands present this cycle.
REQ-006 SHALL have port in_ready, output, 1: adder accepts operands this cycle.
REQ-007 SHALL have port a, input, WIDTH: operand A, unsigned or two's complement.
REQ-008 SHALL have port b, input, WIDTH: operand B.
REQ-009 SHALL have port c_in, input, 1: carry-in, add mode only.
REQ-010 SHALL have port sub, input, 1: 0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid, output, 1: result present.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-013 SHALL have port sum, output, WIDTH: result.
REQ-014 SHALL have port carry, output, 1: carry out of MSB (add), or not-borrow (subtract).
REQ-015 SHALL have port overflow, output, 1: signed two's-complement overflow.

Function
REQ-016 SHALL compute {carry,sum} = a + b + c_in when sub=0.
REQ-017 SHALL compute {carry,sum} = a + ~b + 1 when sub=1; c_in is ignored.
REQ-018 SHALL set overflow = (sign of A == sign of effective B) && (sign of sum != sign of A), where effective B is ~b when sub=1.
REQ-019 SHALL compute one CHUNK slice per stage, with the slice carry registered into the next stage; the upper operand slices SHALL be delay-registered so each slice meets its carry in the same cycle.
REQ-020 SHALL accept a transfer on the cycle in_valid && in_ready, and SHALL present its result on out_valid exactly STAGES cycles later when no stall occurs.
REQ-021 SHALL complete an output transfer on the cycle out_valid && out_ready.
REQ-022 SHALL drive in_ready = !out_valid || out_ready (combinational); no combinational path from in_valid to out_valid.
REQ-023 SHALL freeze all stages and their valid bits, with sum/carry/overflow held stable, while out_valid && !out_ready.
REQ-024 SHALL let bubbles (stages with valid=0) advance while stalled only if this does not overwrite a valid stage; simplest compliant form: global enable = in_ready.
REQ-025 SHALL sustain throughput of one result per cycle when in_valid and out_ready are held high.
REQ-026 SHALL keep results strictly in acceptance order; no operand lost or duplicated.
REQ-027 SHALL propagate a carry across all STAGES boundaries (e.g. 0xFFFF+1).
REQ-028 SHALL reduce to a single registered stage (latency 1) when CHUNK == WIDTH.
REQ-029 SHALL ensure data outputs carry no X when out_valid=0; their value is don't-care.

Reset
REQ-030 SHALL, when rst_n=0 at a clock edge, clear all stage valid bits, out_valid, sum, carry and overflow to 0.
REQ-031 SHALL hold in_ready=1 while out_valid=0, including during and after reset.
REQ-032 SHALL discard in-flight operations on reset mid-operation; no result for them appears after reset release.

Verification (WIDTH=16, CHUNK=4, latency 4)
REQ-033 SHALL cover: add a=0x1234, b=0x4321, c_in=0, out_ready=1 -> 4 cycles later sum=0x5555, carry=0, overflow=0.
REQ-034 SHALL cover: full carry ripple a=0xFFFF, b=0x0000, c_in=1 -> sum=0x0000, carry=1, overflow=0; and add a=0x7FFF, b=0x0001 -> sum=0x8000, overflow=1.
REQ-035 SHALL cover: subtract a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, carry=0; subtract a=0x8000, b=0x0001 -> sum=0x7FFF, overflow=1.
REQ-036 SHALL cover: back-to-back stream of 32 random operands with out_ready=1 -> 32 results in order, one per cycle, all matching a golden model.
REQ-037 SHALL cover: out_ready=0 for 6 cycles mid-stream -> in_ready=0 while out_valid=1, outputs stable, no loss or duplicate after release.
REQ-038 SHALL cover: rst_n=0 for 1 cycle with 3 ops in flight -> out_valid=0 next cycle, in_ready=1, no stale result afterwards.

Source files
------------

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into WIDTH/CHUNK ripple stages.
// Each stage adds one CHUNK slice using the carry registered by the stage below.
// The operand bits not yet added travel alongside that carry.
// The whole pipe advances on one global enable, which is in_ready.
module pipelined_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned STAGES = WIDTH / CHUNK;

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // The pipe moves only when the output register is empty or being drained.
  // This freezes every stage during a stall.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Subtraction is a + ~b + 1, so the forced carry-in replaces c_in.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : c_in;

  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    localparam int unsigned Lo = k * CHUNK;
    localparam int unsigned Hi = Lo + CHUNK;

    // Operand bits still to be added, plus the carry and valid from the stage below
    logic [WIDTH-1:Lo] a_in;
    logic [WIDTH-1:Lo] b_in;
    logic              cin;
    logic              vin;
    logic [CHUNK:0]    slice;
    logic [Hi-1:0]     sum_d;
    logic [Hi-1:0]     sum_q;
    logic              valid_q;
    logic              carry_q;

    if (k == 0) begin : gen_first
      assign a_in  = a;
      assign b_in  = b_eff;
      assign cin   = cin_eff;
      assign vin   = in_valid;
      assign sum_d = slice[CHUNK-1:0];
    end else begin : gen_later
      assign a_in  = gen_stage[k-1].gen_fwd.a_q;
      assign b_in  = gen_stage[k-1].gen_fwd.b_q;
      assign cin   = gen_stage[k-1].carry_q;
      assign vin   = gen_stage[k-1].valid_q;
      assign sum_d = {slice[CHUNK-1:0], gen_stage[k-1].sum_q};
    end

    assign slice = {1'b0, a_in[Lo +: CHUNK]} + {1'b0, b_in[Lo +: CHUNK]}
                 + {{CHUNK{1'b0}}, cin};

    // Stage token and partial sum.
    // Data only loads behind a valid token, so bubbles keep old, X-free values.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (en) begin
        valid_q <= vin;
        if (vin) begin
          carry_q <= slice[CHUNK];
          sum_q   <= sum_d;
        end
      end
    end

    if (k < STAGES - 1) begin : gen_fwd
      logic [WIDTH-1:Hi] a_q;
      logic [WIDTH-1:Hi] b_q;

      // Delay the upper operand slices so each one meets its carry in the next stage
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en && vin) begin
          a_q <= a_in[WIDTH-1:Hi];
          b_q <= b_in[WIDTH-1:Hi];
        end
      end
    end else begin : gen_last
      logic ovf_d;
      logic overflow_q;

      // Top slice holds both operand sign bits and the result sign bit
      assign ovf_d = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (slice[CHUNK-1] != a_in[WIDTH-1]);

      // Signed overflow is registered alongside the final sum slice
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          overflow_q <= 1'b0;
        end else if (en && vin) begin
          overflow_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = gen_stage[STAGES-1].valid_q;
  assign sum       = gen_stage[STAGES-1].sum_q;
  assign carry     = gen_stage[STAGES-1].carry_q;
  assign overflow  = gen_stage[STAGES-1].gen_last.overflow_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: randomized and directed checks of pipelined_adder.
// The results are compared against an integer-arithmetic golden model.
module tb_pipelined_adder;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CHUNK  = 4;
  localparam int unsigned STAGES = WIDTH / CHUNK;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic              c_in = 1'b0;
  logic              sub = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [WIDTH-1:0]  sum;
  logic              carry;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  // Golden results as {carry, overflow, sum}, in acceptance order
  logic [17:0] exp_q[$];

  pipelined_adder #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry    (carry),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Plain integer arithmetic.
  // Carry is unsigned overflow for add and not-borrow for subtract.
  // Overflow means the signed result is out of range.
  function automatic logic [17:0] model(input logic [15:0] oa, input logic [15:0] ob,
                                        input logic ci, input logic sb);
    int ua, ub, sa, sbv, ur, sr;
    logic cy, ov;
    ua  = int'(oa);
    ub  = int'(ob);
    sa  = int'($signed(oa));
    sbv = int'($signed(ob));
    if (sb) begin
      ur = ua - ub;
      sr = sa - sbv;
      cy = (ua >= ub);
    end else begin
      ur = ua + ub + int'(ci);
      sr = sa + sbv + int'(ci);
      cy = (ur > 65535);
    end
    ov = (sr > 32767) || (sr < -32768);
    return {cy, ov, ur[15:0]};
  endfunction

  // Record the golden result of every operand set the DUT accepts
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) exp_q.push_back(model(a, b, c_in, sub));
  end

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if ({carry, overflow, sum} !== 18'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {carry, overflow, sum});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    exp_q.delete();
  endtask

  task automatic test_directed();
    logic [15:0] va[5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] vb[5] = '{16'h4321, 16'h0000, 16'h0001, 16'h0007, 16'h0001};
    logic        vc[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        vs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat;
    logic [17:0] got, exp;
    for (int i = 0; i < 5; i++) begin
      a = va[i]; b = vb[i]; c_in = vc[i]; sub = vs[i];
      in_valid = 1'b1; out_ready = 1'b1;
      lat = 0;
      do begin
        @(posedge clk); #1;
        lat++;
        if (lat == 1) in_valid = 1'b0;
      end while (!out_valid && lat < 12);
      checks++;
      if (lat != STAGES) begin
        errors++; $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, STAGES);
      end
      got = {carry, overflow, sum};
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL directed%0d_result: got %h want <none queued>", i, got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++; $display("FAIL directed%0d_result: got c/v/sum %h want %h", i, got, exp);
        end
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL directed%0d_single: got out_valid %b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0, got_n = 0, cyc = 0, first = -1, last = -1;
    logic [17:0] got, exp;
    out_ready = 1'b1;
    while ((sent < 32 || got_n < 32) && cyc < 200) begin
      if (sent < 32) begin
        a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      if (out_valid) begin
        got = {carry, overflow, sum};
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_result%0d: got %h want <none queued>", got_n, got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++; $display("FAIL b2b_result%0d: got c/v/sum %h want %h", got_n, got, exp);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        got_n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got_n != 32) begin
      errors++; $display("FAIL b2b_count: got %0d results want 32", got_n);
    end
    checks++;
    if (last - first != 31) begin
      errors++; $display("FAIL b2b_rate: got span %0d cycles want 31", last - first);
    end
  endtask

  task automatic test_stall();
    int sent = 0, got_n = 0, cyc = 0, stall_n = 0;
    logic new_op = 1'b1, stalled = 1'b0;
    logic [17:0] got, exp, held;
    held = '0;
    while ((sent < 20 || exp_q.size() != 0) && cyc < 100) begin
      if (sent < 20) begin
        if (new_op) begin
          a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
        end
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (cyc < 8 || cyc >= 14);
      @(negedge clk);
      new_op = in_valid && in_ready;
      if (new_op) sent++;
      got = {carry, overflow, sum};
      if (out_valid && !out_ready) begin
        stall_n++;
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL stall_in_ready: got %b want 0 (cycle %0d)", in_ready, cyc);
        end
        if (stalled) begin
          checks++;
          if (got !== held) begin
            errors++; $display("FAIL stall_hold: got %h want %h (cycle %0d)", got, held, cyc);
          end
        end
        held = got;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stall_result%0d: got %h want <none queued>", got_n, got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++; $display("FAIL stall_result%0d: got c/v/sum %h want %h", got_n, got, exp);
          end
        end
        got_n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (stall_n != 6) begin
      errors++; $display("FAIL stall_cycles: got %0d stalled cycles want 6", stall_n);
    end
    checks++;
    if (got_n != 20 || sent != 20) begin
      errors++; $display("FAIL stall_count: got %0d results of %0d sent want 20", got_n, sent);
    end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_flush: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    checks++;
    if ({carry, overflow, sum} !== 18'h0) begin
      errors++; $display("FAIL midreset_data: got %h want 0", {carry, overflow, sum});
    end
    rst_n = 1'b1;
    exp_q.delete();
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midreset_stale: got %0d stale results want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
